// File: rtl/maxpool_flatten_buf_if.sv
// Stream bundle between the second max-pool layer, the flatten buffer and the FC stage.
// The slave side is the buffer; the master side drives pooled beats and FC ready.
interface maxpool_flatten_buf_if #(
  parameter int CHANNELS = 16,
  parameter int IDX_W    = 5
);
  logic [CHANNELS-1:0] pool_in;
  logic                pool_valid;
  logic [CHANNELS-1:0] feat_data;
  logic [IDX_W-1:0]    feat_index;
  logic                feat_valid;
  logic                feat_last;
  logic                feat_ready;
  logic [7:0]          frame_cnt;
  logic                overflow;

  modport master (
    output pool_in, pool_valid, feat_ready,
    input  feat_data, feat_index, feat_valid, feat_last, frame_cnt, overflow
  );

  modport slave (
    input  pool_in, pool_valid, feat_ready,
    output feat_data, feat_index, feat_valid, feat_last, frame_cnt, overflow
  );
endinterface

// File: rtl/maxpool_flatten_buf.sv
// Captures one frame of pooled 16-channel words, then replays it in raster order
// as a back-pressurable stream for the fully-connected stage.
module maxpool_flatten_buf #(
  parameter int OUT_WIDTH  = 5,
  parameter int OUT_HEIGHT = 5,
  parameter int CHANNELS   = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  maxpool_flatten_buf_if.slave  bus
);
  localparam int NPOS  = OUT_WIDTH * OUT_HEIGHT;
  localparam int IDX_W = $clog2(NPOS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOS - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    wr_ptr_q;
  logic [IDX_W-1:0]    rd_ptr_q;
  logic [IDX_W-1:0]    rd_ptr_d;
  logic [CHANNELS-1:0] mem [NPOS];
  logic [CHANNELS-1:0] feat_data_q;
  logic                feat_valid_q;
  logic                feat_last_q;
  logic [7:0]          frame_cnt_q;
  logic                overflow_q;

  assign rd_ptr_d = rd_ptr_q + 1'b1;

  // Beats arriving while draining are never written, so the frame being replayed stays intact.
  always_ff @(posedge clk) begin
    if (state_q == FILL && bus.pool_valid) begin
      mem[wr_ptr_q] <= bus.pool_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      feat_data_q  <= '0;
      feat_valid_q <= 1'b0;
      feat_last_q  <= 1'b0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.pool_valid) begin
            if (wr_ptr_q == LAST_IDX) begin
              // Word 0 was captured on an earlier beat, so it can be presented right away.
              wr_ptr_q     <= '0;
              state_q      <= DRAIN;
              feat_valid_q <= 1'b1;
              feat_last_q  <= 1'b0;
              feat_data_q  <= mem[0];
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.pool_valid) begin
            overflow_q <= 1'b1;
          end
          if (bus.feat_ready) begin
            if (feat_last_q) begin
              state_q      <= FILL;
              rd_ptr_q     <= '0;
              frame_cnt_q  <= frame_cnt_q + 1'b1;
              feat_valid_q <= 1'b0;
              feat_last_q  <= 1'b0;
              feat_data_q  <= '0;
            end else begin
              rd_ptr_q    <= rd_ptr_d;
              feat_data_q <= mem[rd_ptr_d];
              feat_last_q <= (rd_ptr_d == LAST_IDX);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.feat_data  = feat_data_q;
  assign bus.feat_index = rd_ptr_q;
  assign bus.feat_valid = feat_valid_q;
  assign bus.feat_last  = feat_last_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_maxpool_flatten_buf.sv
// Randomized bench for maxpool_flatten_buf: a queue-based frame model predicts
// every output each cycle; scenario tasks cover fill patterns, stalls, collisions and wrap.
module tb_maxpool_flatten_buf;
  localparam int NPOS = 25;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ready_mode = 0;   // 0: tied high, 1: random 30%, 2: held low
  int   hs_total = 0;

  maxpool_flatten_buf_if #(.CHANNELS(16), .IDX_W(5)) bus ();

  maxpool_flatten_buf #(.OUT_WIDTH(5), .OUT_HEIGHT(5), .CHANNELS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame model: words collect in m_fill until a frame is complete, then replay from m_drain.
  logic [15:0] m_fill[$];
  logic [15:0] m_drain[$];
  int          m_rd = 0;
  int          m_frames = 0;
  bit          m_ovf = 1'b0;

  always @(negedge clk) begin
    bit draining;
    draining = (m_drain.size() > 0);
    check("valid", 32'(bus.feat_valid), 32'(draining));
    if (draining) begin
      check("index", 32'(bus.feat_index), 32'(m_rd));
      check("data", 32'(bus.feat_data), 32'(m_drain[0]));
      check("last", 32'(bus.feat_last), 32'(m_rd == NPOS - 1));
    end else begin
      check("idle_word", {bus.feat_data, 10'd0, bus.feat_index, bus.feat_last}, 32'd0);
    end
    check("frame_cnt", 32'(bus.frame_cnt), 32'(m_frames % 256));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (bus.feat_valid === 1'b1 && bus.feat_ready === 1'b1) hs_total++;

    if (!rst_n) begin
      m_fill = {};
      m_drain = {};
      m_rd = 0;
      m_frames = 0;
      m_ovf = 1'b0;
    end else begin
      if (bus.pool_valid) begin
        if (draining) m_ovf = 1'b1;
        else m_fill.push_back(bus.pool_in);
      end
      if (draining && bus.feat_ready) begin
        void'(m_drain.pop_front());
        m_rd++;
        if (m_drain.size() == 0) begin
          m_rd = 0;
          m_frames++;
        end
      end
      if (m_fill.size() == NPOS) begin
        m_drain = m_fill;
        m_fill = {};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.feat_ready = 1'b1;
      1:       bus.feat_ready = ($urandom_range(0, 99) < 30);
      default: bus.feat_ready = 1'b0;
    endcase
  endtask

  // kind 0: index, 1: A5A5/5A5A alternating, 3: all ones, otherwise random
  task automatic fill_frame(input int kind, input int gap);
    logic [15:0] d;
    for (int i = 0; i < NPOS; i++) begin
      case (kind)
        0:       d = 16'(i);
        1:       d = (i % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
        3:       d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      bus.pool_valid = 1'b1;
      bus.pool_in    = d;
      step();
      bus.pool_valid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic wait_idle(input bit noisy, input string tag);
    int n = 0;
    while (bus.feat_valid === 1'b1 && n < 400) begin
      if (noisy) begin
        bus.pool_valid = 1'($urandom_range(0, 1));
        bus.pool_in    = 16'($urandom);
      end
      step();
      n++;
    end
    bus.pool_valid = 1'b0;
    check({tag, "_drained"}, 32'(bus.feat_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int hs0;
    int n;
    rst_n          = 1'b0;
    bus.pool_in    = '0;
    bus.pool_valid = 1'b0;
    bus.feat_ready = 1'b1;
    do_reset();

    // Back-to-back index frame.
    hs0 = hs_total;
    fill_frame(0, 0);
    wait_idle(1'b0, "seq");
    check("seq_hs", 32'(hs_total - hs0), 32'd25);
    check("seq_frames", 32'(bus.frame_cnt), 32'd1);

    // Sparse alternating pattern.
    hs0 = hs_total;
    fill_frame(1, 2);
    wait_idle(1'b0, "sparse");
    check("sparse_hs", 32'(hs_total - hs0), 32'd25);

    // Random back-pressure with stray beats during drain.
    ready_mode = 1;
    hs0 = hs_total;
    fill_frame(2, 0);
    wait_idle(1'b1, "bp");
    check("bp_hs", 32'(hs_total - hs0), 32'd25);

    // Collision while stalled.
    ready_mode = 2;
    fill_frame(2, 0);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      bus.pool_valid = 1'b1;
      bus.pool_in    = 16'($urandom);
      step();
    end
    bus.pool_valid = 1'b0;
    step();
    check("ovf_set", 32'(bus.overflow), 32'd1);
    ready_mode = 0;
    wait_idle(1'b0, "coll");
    fill_frame(2, 1);
    wait_idle(1'b0, "clean");
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset after 10 handshakes of a drain.
    fill_frame(2, 0);
    hs0 = hs_total;
    n = 0;
    while (hs_total - hs0 < 10 && n < 100) begin
      step();
      n++;
    end
    check("mid_hs", 32'(hs_total - hs0), 32'd10);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_valid", 32'(bus.feat_valid), 32'd0);
    check("rst_frames", 32'(bus.frame_cnt), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    fill_frame(3, 0);
    wait_idle(1'b0, "ones");

    // Frame counter wrap.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      fill_frame(2, 0);
      wait_idle(1'b1, "wrapf");
      if (f == 254) check("cnt_255", 32'(bus.frame_cnt), 32'd255);
    end
    check("cnt_wrap", 32'(bus.frame_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/maxpool_flatten_buf.md
Name: maxpool_flatten_buf

Overview:
- Sink end of the pooled-feature stream. Captures one full frame of 16-channel binary max-pool outputs, which arrive at irregular cycles qualified by the pooling valid, into a position-indexed buffer.
- Once the frame is complete, re-emits it to the fully-connected stage as a flattened, back-pressurable valid/ready stream, one word per pooled position.
- Sits between the second max-pooling layer and the FC layer.

Parameters:
OUT_WIDTH, 5, pooled frame width in positions
OUT_HEIGHT, 5, pooled frame height in positions
CHANNELS, 16, binary channels per position (word width)
NPOS (localparam), OUT_WIDTH*OUT_HEIGHT = 25, words per frame
IDX_W (localparam), clog2(NPOS) = 5, index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pool_in  in  CHANNELS  pooled pixels; bit i = channel i+1 (bit 0 = maxpool_out_1)
pool_valid  in  1  pool_in valid this cycle (the pooling layer's AND-ed valid)
feat_data  out  CHANNELS  flattened word for position feat_index
feat_index  out  IDX_W  raster position of feat_data (row*OUT_WIDTH+col)
feat_valid  out  1  feat_data/feat_index valid
feat_last  out  1  high with the final word (index NPOS-1) of a frame
feat_ready  in  1  FC stage accepts the word this cycle
frame_cnt  out  8  completed drained frames, wraps 255->0
overflow  out  1  sticky: a pool_valid beat arrived while draining and was dropped

Behaviour:
- Reset (rst_n=0 at a clk edge): state=FILL, wr_ptr=0, rd_ptr=0. Outputs: feat_valid=0, feat_last=0, feat_index=0, feat_data=0, frame_cnt=0, overflow=0. Buffer contents are don't-care.
- Reset mid-frame or mid-drain discards the partial frame. No word is emitted after reset until a new full frame is captured.
- Storage: NPOS x CHANNELS register array mem.
- State FILL:
  - On pool_valid=1: mem[wr_ptr]<=pool_in and wr_ptr++.
  - When pool_valid=1 and wr_ptr==NPOS-1: wr_ptr<=0, state<=DRAIN.
  - pool_valid=0 cycles are ignored; there is no timeout between beats.
- State DRAIN:
  - feat_valid=1, feat_index=rd_ptr, feat_data=mem[rd_ptr], feat_last=(rd_ptr==NPOS-1).
  - All outputs are held stable while feat_ready=0.
  - feat_valid&&feat_ready: rd_ptr++.
  - On the handshake with feat_last=1: rd_ptr<=0, frame_cnt++, state<=FILL.
- Latency: the capture edge of the last input beat (cycle t) is followed by feat_valid=1 with index 0 in cycle t+1. With feat_ready tied high, a frame drains in exactly NPOS cycles (t+1..t+NPOS). FILL is re-entered at cycle t+NPOS+1, and a pool_valid beat in that cycle is captured as index 0.
- Back-pressure: feat_ready may toggle arbitrarily. No word is skipped or duplicated. feat_valid never drops without a handshake.
- Drain/fill collision: pool_valid=1 in any DRAIN cycle, including the cycle of the last handshake, drops the beat. overflow<=1 and stays 1 until reset. mem and wr_ptr are unaffected.
- feat_valid is 0 in FILL. feat_data/feat_index/feat_last are don't-care when feat_valid=0, but are driven 0 in FILL.
- Pointers never exceed NPOS-1. frame_cnt wraps modulo 256.
- No combinational path from pool_* to feat_*. feat_ready may combinationally affect nothing except next-state logic.

Test Plan:
- Reset then 25 pool_valid beats back-to-back with pool_in=index (0x0000..0x0018), feat_ready=1 -> feat_valid rises the cycle after beat 25. Words 0x0000..0x0018 appear at indices 0..24 on consecutive cycles, feat_last only at index 24, frame_cnt=1, overflow=0.
- Sparse input: beats every 3rd cycle (the pooling-layer pattern), pool_in=0xA5A5 for even indices and 0x5A5A for odd -> exactly 25 words drained, alternating in order, and no feat_valid before the 25th beat.
- Back-pressure: feat_ready pseudo-random at 30% duty during drain -> feat_data/feat_index stable while stalled, 25 unique handshakes, frame_cnt=1.
- Collision: feat_ready=0 during drain with 3 pool_valid beats injected -> overflow=1 (sticky). Drained data equals the first frame. A following clean frame of 25 beats drains correctly with overflow still 1.
- Reset mid-drain after 10 handshakes -> next cycle feat_valid=0, frame_cnt=0, overflow=0. A new 25-beat frame of 0xFFFF drains from index 0.
- 256 consecutive frames -> frame_cnt wraps to 0 after the 256th feat_last handshake.
